ref_timer: RTL and testbench

- Refresh request generator for the DRAM controller.
- Divides CLK into fixed refresh intervals and keeps a count of owed refreshes.
- Drives the controller's RefReqIn/RefUrgentIn inputs and consumes its per-refresh acknowledge.
- Guarantees RefReq drops between successive refreshes, because the controller's done-latch only re-arms while RefReq is low.

---
 rtl/ref_timer.sv | 139 +++++++++++++
 tb/tb_ref_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ref_timer.sv
// Refresh request generator: divides CLK into refresh intervals, tracks owed
// refreshes and hands them to the DRAM controller one request at a time.
module ref_timer #(
   parameter int REF_PERIOD   = 384,
   parameter int URGENT_DELAY = 192,
   parameter int GAP_CYCLES   = 2,
   parameter int DEBT_MAX     = 3
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       En,
   input  logic       RefAck,
   output logic       RefReq,
   output logic       RefUrgent,
   output logic [1:0] Debt,
   output logic       Overrun
);

   localparam int CNT_W = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
   localparam int AGE_W = $clog2(URGENT_DELAY + 1);
   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);
   localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(URGENT_DELAY);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
   localparam logic [1:0]       DEBT_SAT = 2'(DEBT_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [AGE_W-1:0] age_reg, age_next;
   logic [GAP_W-1:0] gap_reg, gap_next;
   logic [1:0]       debt_reg, debt_next;
   logic             overrun_reg, overrun_next;
   logic             req_reg, req_next;
   logic             urgent_reg, urgent_next;
   logic             tick;
   logic             ackv;

   assign tick = En && (cnt_reg == CNT_LAST);
   // Acks are only meaningful while a request is outstanding.
   assign ackv = RefAck && (state_reg == PEND);

   always_comb begin
      cnt_next = cnt_reg;
      if (En) begin
         cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      end
   end

   always_comb begin
      debt_next    = debt_reg;
      overrun_next = overrun_reg;
      if (tick && !ackv) begin
         if (debt_reg == DEBT_SAT) begin
            overrun_next = 1'b1;
         end else begin
            debt_next = debt_reg + 2'd1;
         end
      end else if (ackv && !tick) begin
         debt_next = debt_reg - 2'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      age_next   = age_reg;
      gap_next   = gap_reg;
      unique case (state_reg)
         IDLE: begin
            if (debt_next != 2'd0) begin
               state_next = PEND;
               age_next   = '0;
            end
         end
         PEND: begin
            if (ackv) begin
               state_next = GAP;
               gap_next   = GAP_INIT;
            end else if (age_reg != AGE_SAT) begin
               age_next = age_reg + 1'b1;
            end
         end
         GAP: begin
            // Holding RefReq low here lets the controller's done-latch re-arm.
            if (gap_reg != '0) begin
               gap_next = gap_reg - 1'b1;
            end else if (debt_next != 2'd0) begin
               state_next = PEND;
               age_next   = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      req_next    = (state_next == PEND);
      urgent_next = (state_next == PEND) &&
                    ((age_next >= AGE_SAT) || (debt_next >= 2'd2));
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         age_reg     <= '0;
         gap_reg     <= '0;
         debt_reg    <= 2'd0;
         overrun_reg <= 1'b0;
         req_reg     <= 1'b0;
         urgent_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         age_reg     <= age_next;
         gap_reg     <= gap_next;
         debt_reg    <= debt_next;
         overrun_reg <= overrun_next;
         req_reg     <= req_next;
         urgent_reg  <= urgent_next;
      end
   end

   assign RefReq    = req_reg;
   assign RefUrgent = urgent_reg;
   assign Debt      = debt_reg;
   assign Overrun   = overrun_reg;

endmodule

// File: tb/tb_ref_timer.sv
// Directed bench for ref_timer with a short refresh interval (16 clocks).
module tb_ref_timer;

   logic       CLK;
   logic       nRESET;
   logic       En;
   logic       RefAck;
   logic       RefReq;
   logic       RefUrgent;
   logic [1:0] Debt;
   logic       Overrun;

   int n_cmp;
   int n_bad;

   ref_timer #(
      .REF_PERIOD  (16),
      .URGENT_DELAY(8),
      .GAP_CYCLES  (2),
      .DEBT_MAX    (3)
   ) dut (
      .CLK      (CLK),
      .nRESET   (nRESET),
      .En       (En),
      .RefAck   (RefAck),
      .RefReq   (RefReq),
      .RefUrgent(RefUrgent),
      .Debt     (Debt),
      .Overrun  (Overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
      $display("t=%0t %s obs=%0h exp=%0h", $time, tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic req, input logic urg,
                          input logic [1:0] dbt, input logic ovr);
      chk({tag, ".req"}, 32'(RefReq), 32'(req));
      chk({tag, ".urg"}, 32'(RefUrgent), 32'(urg));
      chk({tag, ".debt"}, 32'(Debt), 32'(dbt));
      chk({tag, ".ovr"}, 32'(Overrun), 32'(ovr));
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      nRESET = 1'b0;
      En     = 1'b1;
      RefAck = 1'b0;

      edges(3);
      chk_all("reset", 1'b0, 1'b0, 2'd0, 1'b0);

      // Edge numbering restarts at 0 here; counter is 0.
      nRESET = 1'b1;
      edges(15);
      chk_all("pre_tick", 1'b0, 1'b0, 2'd0, 1'b0);
      edges(1);                                  // edge 16: first tick
      chk_all("first_tick", 1'b1, 1'b0, 2'd1, 1'b0);
      edges(7);                                  // edge 23: age 7
      chk("age7.urg", 32'(RefUrgent), 32'd0);
      edges(1);                                  // edge 24: age 8
      chk("age8.urg", 32'(RefUrgent), 32'd1);
      edges(8);                                  // edge 32: second tick
      chk_all("second_tick", 1'b1, 1'b1, 2'd2, 1'b0);

      // Ack with Debt=2: gap then re-request with age restarted.
      RefAck = 1'b1;
      edges(1);                                  // edge 33
      RefAck = 1'b0;
      chk_all("ack_d2", 1'b0, 1'b0, 2'd1, 1'b0);
      edges(1);                                  // edge 34
      chk("gap2.req", 32'(RefReq), 32'd0);
      edges(1);                                  // edge 35: back in PEND
      chk_all("re_pend", 1'b1, 1'b0, 2'd1, 1'b0);
      edges(7);                                  // edge 42
      chk("re_age7.urg", 32'(RefUrgent), 32'd0);
      edges(1);                                  // edge 43
      chk("re_age8.urg", 32'(RefUrgent), 32'd1);

      // Ack with Debt=1: go idle; stray acks in GAP/IDLE ignored.
      RefAck = 1'b1;
      edges(1);                                  // edge 44
      chk_all("ack_d1", 1'b0, 1'b0, 2'd0, 1'b0);
      edges(1);                                  // edge 45: ack seen in GAP
      RefAck = 1'b0;
      chk("gap_ack.debt", 32'(Debt), 32'd0);
      chk("gap_ack.req", 32'(RefReq), 32'd0);
      edges(1);                                  // edge 46: IDLE
      chk("idle.req", 32'(RefReq), 32'd0);
      RefAck = 1'b1;
      edges(1);                                  // edge 47: ack seen in IDLE
      RefAck = 1'b0;
      chk("idle_ack.debt", 32'(Debt), 32'd0);
      chk("idle_ack.req", 32'(RefReq), 32'd0);
      edges(1);                                  // edge 48: tick
      chk_all("third_tick", 1'b1, 1'b0, 2'd1, 1'b0);

      // Tick and ack on the same edge with Debt=1.
      edges(15);                                 // edge 63
      chk("pre_coinc.urg", 32'(RefUrgent), 32'd1);
      RefAck = 1'b1;
      edges(1);                                  // edge 64: tick + ack
      RefAck = 1'b0;
      chk_all("coinc", 1'b0, 1'b0, 2'd1, 1'b0);
      edges(1);                                  // edge 65
      chk("coinc_gap.req", 32'(RefReq), 32'd0);
      edges(1);                                  // edge 66
      chk_all("coinc_re", 1'b1, 1'b0, 2'd1, 1'b0);

      // Let debt pile up to saturation and overrun.
      edges(14);                                 // edge 80
      chk("sat80.debt", 32'(Debt), 32'd2);
      edges(16);                                 // edge 96
      chk_all("sat96", 1'b1, 1'b1, 2'd3, 1'b0);
      edges(16);                                 // edge 112
      chk_all("sat112", 1'b1, 1'b1, 2'd3, 1'b1);
      RefAck = 1'b1;
      edges(1);                                  // edge 113
      RefAck = 1'b0;
      chk_all("ovr_ack", 1'b0, 1'b0, 2'd2, 1'b1);
      edges(2);                                  // edge 115: PEND, Debt=2
      chk_all("ovr_re", 1'b1, 1'b1, 2'd2, 1'b1);

      // Asynchronous reset in the middle of PEND.
      #2;
      nRESET = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 2'd0, 1'b0);

      // En low: counter frozen, no ticks.
      En = 1'b0;
      edges(2);
      nRESET = 1'b1;
      edges(40);
      chk_all("en_off", 1'b0, 1'b0, 2'd0, 1'b0);
      En = 1'b1;
      edges(10);                                 // counter at 10
      En = 1'b0;
      edges(20);
      chk("frozen.req", 32'(RefReq), 32'd0);
      En = 1'b1;
      edges(5);                                  // counter at 15
      chk("resume_pre.req", 32'(RefReq), 32'd0);
      edges(1);                                  // tick
      chk("resume_tick.req", 32'(RefReq), 32'd1);
      chk("resume_tick.debt", 32'(Debt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
